// File: rtl/gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker
//   Stimulus/response stage for small combinational gates. When start is
//   pulsed, every input vector 0..2^N_IN-1 is driven on dut_in in ascending
//   order. Each vector is held for SETTLE+1 cycles. On the last cycle of the
//   hold window, dut_out is compared with EXP_TT[dut_in]. Results stay valid
//   in DONE until the next start or reset.
//
// Parameters
//   N_IN    number of gate inputs (1..4)
//   EXP_TT  expected truth table; bit i = expected output for vector i
//   SETTLE  extra cycles each vector is held before it is sampled (>=0)
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset (wins over start)
//   start       one-cycle sweep request; ignored while busy
//   dut_out     output of the gate under test
//   dut_in      vector driven into the gate under test
//   busy        sweep in progress
//   done        sweep finished, results valid
//   pass        done with zero mismatches
//   err_count   number of mismatching vectors
//   fail_valid  at least one mismatch recorded
//   fail_vec    first (lowest) mismatching vector
// ---------------------------------------------------------------------------
module gate_sweep_checker #(
   parameter int unsigned             N_IN   = 2,
   parameter logic [(1<<N_IN)-1:0]    EXP_TT = 4'b0111,
   parameter int unsigned             SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            dut_out,
   output logic [N_IN-1:0] dut_in,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            fail_valid,
   output logic [N_IN-1:0] fail_vec
);

   localparam int unsigned EW = N_IN + 1;
   localparam int unsigned CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'((1 << N_IN) - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [EW-1:0]   err_q, err_d;
   logic            fv_q, fv_d;
   logic [N_IN-1:0] fvec_q, fvec_d;

   logic            exp_bit;
   logic            match;
   logic [EW-1:0]   err_next;

   assign exp_bit = EXP_TT[vec_q];
   // An x/z on dut_out makes match unknown. The if() below then takes its
   // else branch, so the vector is counted as a mismatch.
   assign match   = (dut_out == exp_bit);

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      err_d    = err_q;
      fv_d     = fv_q;
      fvec_d   = fvec_q;
      err_next = err_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               vec_d  = '0;
               busy_d = 1'b1;
               done_d = 1'b0;
               pass_d = 1'b0;
               err_d  = '0;
               fv_d   = 1'b0;
               fvec_d = '0;
               cnt_d  = CW'(SETTLE);
               state_d = (SETTLE == 0) ? S_SAMPLE : S_HOLD;
            end
         end

         S_HOLD: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_SAMPLE;
            end
         end

         S_SAMPLE: begin
            if (match) begin
               err_next = err_q;
            end else begin
               err_next = err_q + EW'(1);
               if (!fv_q) begin
                  fv_d   = 1'b1;
                  fvec_d = vec_q;
               end
            end
            err_d = err_next;

            if (vec_q == LAST_VEC) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               // Use the count that includes this last sample.
               pass_d  = (err_next == '0);
            end else begin
               vec_d   = vec_q + N_IN'(1);
               cnt_d   = CW'(SETTLE);
               state_d = (SETTLE == 0) ? S_SAMPLE : S_HOLD;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fv_q    <= 1'b0;
         fvec_q  <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         fvec_q  <= fvec_d;
      end
   end

   assign dut_in     = vec_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fv_q;
   assign fail_vec   = fvec_q;

endmodule
